// File: rtl/ccd_cfg_pkg.sv
// Shared types and constant register table for the CCD sensor configuration sequencer.
package ccd_cfg_pkg;

  typedef enum logic [2:0] {
    ST_SETTLE,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int CFG_LEN = 8;
  localparam int IDX_W   = 3;
  localparam logic [IDX_W-1:0] IDX_EXP = 3'd1;

  localparam logic [7:0] REG_ROW_START = 8'h01;
  localparam logic [7:0] REG_COL_START = 8'h02;
  localparam logic [7:0] REG_ROW_SIZE  = 8'h03;
  localparam logic [7:0] REG_COL_SIZE  = 8'h04;
  localparam logic [7:0] REG_SHUTTER   = 8'h09;
  localparam logic [7:0] REG_ROW_MODE  = 8'h22;
  localparam logic [7:0] REG_COL_MODE  = 8'h23;
  localparam logic [7:0] REG_GAIN      = 8'h35;

  localparam logic [15:0] SKIP_ZOOM   = 16'h0000;
  localparam logic [15:0] SKIP_NORMAL = 16'h0033;

  localparam logic [7:0] CFG_REG [CFG_LEN] = '{
    REG_ROW_START, REG_SHUTTER, REG_COL_START, REG_ROW_SIZE,
    REG_COL_SIZE, REG_ROW_MODE, REG_COL_MODE, REG_GAIN
  };

  // Entries 1, 5 and 6 are placeholders; their data is substituted at lookup.
  localparam logic [15:0] CFG_DATA [CFG_LEN] = '{
    16'h0036, 16'h0000, 16'h0010, 16'h077F,
    16'h09FF, 16'h0000, 16'h0000, 16'h0008
  };

endpackage

// File: rtl/ccd_config_sequencer_if.sv
// Write-command channel between the configuration sequencer and the I2C master.
interface ccd_config_sequencer_if;
  logic        ocmd_valid;
  logic [7:0]  ocmd_slave;
  logic [7:0]  ocmd_reg;
  logic [15:0] ocmd_data;
  logic        icmd_ready;
  logic        icmd_done;
  logic        icmd_nack;

  modport master (
    output ocmd_valid, ocmd_slave, ocmd_reg, ocmd_data,
    input  icmd_ready, icmd_done, icmd_nack
  );

  modport slave (
    input  ocmd_valid, ocmd_slave, ocmd_reg, ocmd_data,
    output icmd_ready, icmd_done, icmd_nack
  );
endinterface

// File: rtl/ccd_cfg_rom.sv
// Combinational table lookup: index plus live zoom/exposure values -> register write.
module ccd_cfg_rom
  import ccd_cfg_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             zoom,
  input  logic [15:0]      exposure,
  output logic [7:0]       reg_addr,
  output logic [15:0]      reg_data
);

  always_comb begin
    reg_addr = CFG_REG[idx];
    reg_data = CFG_DATA[idx];
    if (reg_addr == REG_SHUTTER) begin
      reg_data = exposure;
    end else if (reg_addr == REG_ROW_MODE || reg_addr == REG_COL_MODE) begin
      reg_data = zoom ? SKIP_ZOOM : SKIP_NORMAL;
    end
  end

endmodule

// File: rtl/ccd_config_sequencer.sv
// Sequences the CCD register table over I2C, with NACK retry, exposure
// push-button stepping and zoom-triggered re-sequencing.
module ccd_config_sequencer
  import ccd_cfg_pkg::*;
#(
  parameter logic [7:0]  SLAVE_ADDR    = 8'hBA,
  parameter logic [15:0] EXP_DEFAULT   = 16'h0797,
  parameter logic [15:0] EXP_STEP      = 16'h0100,
  parameter int          MAX_RETRY     = 3,
  parameter int          SETTLE_CYCLES = 16
) (
  input  logic                   iclk,
  input  logic                   irst,
  input  logic                   istart_cfg,
  input  logic                   iexposure_adj,
  input  logic                   iexposure_dec_p,
  input  logic                   izoom_mode_sw,
  ccd_config_sequencer_if.master cmd,
  output logic                   obusy,
  output logic                   oconfig_done,
  output logic                   oerror,
  output logic [15:0]            oexposure
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [15:0]      settle_cnt;
  logic [7:0]       retry;
  logic             pend_full, pend_exp, exp_only;
  logic [15:0]      exposure;
  logic             adj_p0, adj_p1, adj_p2;
  logic             zoom_p0, zoom_p1, zoom_p2;
  logic [7:0]       rom_reg, cmd_reg;
  logic [15:0]      rom_data, cmd_data;
  logic             adj_rise, zoom_chg, set_full, svc_full, svc_exp;
  logic             load, acked, nacked;

  function automatic logic [15:0] exp_step_sat(input logic [15:0] cur, input logic dec);
    logic [16:0] sum;
    if (dec) begin
      return (cur < EXP_STEP) ? 16'h0000 : cur - EXP_STEP;
    end
    sum = {1'b0, cur} + {1'b0, EXP_STEP};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // p0/p1 form the synchroniser; p2 holds the previous synchronised level.
  assign adj_rise = adj_p1 & ~adj_p2;
  assign zoom_chg = zoom_p1 ^ zoom_p2;
  assign set_full = zoom_chg | (istart_cfg && state != ST_ERROR);
  assign svc_full = (state == ST_DONE) && pend_full;
  assign svc_exp  = (state == ST_DONE) && !pend_full && pend_exp;
  assign acked    = (state == ST_WAIT) && cmd.icmd_done && !cmd.icmd_nack;
  assign nacked   = (state == ST_WAIT) && cmd.icmd_done && cmd.icmd_nack;
  assign load     = (state_nxt == ST_ISSUE) && (state != ST_ISSUE);

  ccd_cfg_rom u_rom (
    .idx      (idx_nxt),
    .zoom     (zoom_p1),
    .exposure (exposure),
    .reg_addr (rom_reg),
    .reg_data (rom_data)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_SETTLE: if (settle_cnt >= 16'(SETTLE_CYCLES - 1)) begin
        state_nxt = ST_ISSUE;
        idx_nxt   = '0;
      end
      ST_ISSUE: if (cmd.icmd_ready) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (acked) state_nxt = ST_NEXT;
        else if (nacked) state_nxt = (retry < 8'(MAX_RETRY)) ? ST_ISSUE : ST_ERROR;
      end
      ST_NEXT: begin
        if (exp_only || idx == IDX_W'(CFG_LEN - 1)) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_ISSUE;
          idx_nxt   = idx + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (pend_full) begin
          state_nxt = ST_ISSUE;
          idx_nxt   = '0;
        end else if (pend_exp) begin
          state_nxt = ST_ISSUE;
          idx_nxt   = IDX_EXP;
        end
      end
      ST_ERROR: if (istart_cfg) begin
        state_nxt = ST_ISSUE;
        idx_nxt   = '0;
      end
      default: state_nxt = ST_SETTLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (!irst) begin
      state      <= ST_SETTLE;
      idx        <= '0;
      settle_cnt <= '0;
      retry      <= '0;
      pend_full  <= 1'b0;
      pend_exp   <= 1'b0;
      exp_only   <= 1'b0;
      exposure   <= EXP_DEFAULT;
      oexposure  <= EXP_DEFAULT;
      {adj_p0, adj_p1, adj_p2}    <= '0;
      {zoom_p0, zoom_p1, zoom_p2} <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      adj_p0  <= iexposure_adj;
      adj_p1  <= adj_p0;
      adj_p2  <= adj_p1;
      zoom_p0 <= izoom_mode_sw;
      zoom_p1 <= zoom_p0;
      zoom_p2 <= zoom_p1;
      if (state == ST_SETTLE) settle_cnt <= settle_cnt + 16'd1;
      if (adj_rise) exposure <= exp_step_sat(exposure, iexposure_dec_p);
      // A new event in the servicing cycle must survive the clear.
      pend_full <= set_full | (pend_full & ~svc_full);
      pend_exp  <= adj_rise | (pend_exp & ~(svc_full | svc_exp));
      if (state == ST_NEXT) retry <= '0;
      else if (nacked && retry < 8'(MAX_RETRY)) retry <= retry + 8'd1;
      else if (load && state != ST_WAIT) retry <= '0;
      if (svc_full || (state == ST_ERROR && istart_cfg)) exp_only <= 1'b0;
      else if (svc_exp) exp_only <= 1'b1;
      if (acked && idx == IDX_EXP) oexposure <= cmd_data;
    end
  end

  // Payload is captured on entry to ISSUE so it cannot move while stalled.
  always_ff @(posedge iclk) begin
    if (load) begin
      cmd_reg  <= rom_reg;
      cmd_data <= rom_data;
    end
  end

  assign cmd.ocmd_valid = (state == ST_ISSUE);
  assign cmd.ocmd_slave = SLAVE_ADDR;
  assign cmd.ocmd_reg   = cmd_reg;
  assign cmd.ocmd_data  = cmd_data;
  assign obusy          = (state == ST_SETTLE) || (state == ST_ISSUE) ||
                          (state == ST_WAIT) || (state == ST_NEXT);
  assign oconfig_done   = (state == ST_DONE);
  assign oerror         = (state == ST_ERROR);

endmodule

// File: tb/tb_ccd_config_sequencer.sv
// Directed bench for ccd_config_sequencer with a behavioural I2C master responder.
module tb_ccd_config_sequencer;

  logic iclk = 1'b0;
  logic irst = 1'b0;
  logic istart_cfg = 1'b0;
  logic iexposure_adj = 1'b0;
  logic iexposure_dec_p = 1'b0;
  logic izoom_mode_sw = 1'b0;
  logic cmd_ready = 1'b1;
  logic obusy, oconfig_done, oerror;
  logic [15:0] oexposure;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]  log_reg[$];
  logic [15:0] log_data[$];
  int          nack_left = 0;
  logic [7:0]  nack_reg = 8'h00;
  int          rsp_timer = 0;
  logic [7:0]  rsp_reg = 8'h00;

  localparam logic [7:0]  EXP_REGS [8] = '{8'h01, 8'h09, 8'h02, 8'h03, 8'h04, 8'h22, 8'h23, 8'h35};
  localparam logic [15:0] EXP_DATA [8] = '{16'h0036, 16'h0797, 16'h0010, 16'h077F,
                                           16'h09FF, 16'h0033, 16'h0033, 16'h0008};

  ccd_config_sequencer_if bus();
  assign bus.icmd_ready = cmd_ready;

  ccd_config_sequencer dut (
    .iclk            (iclk),
    .irst            (irst),
    .istart_cfg      (istart_cfg),
    .iexposure_adj   (iexposure_adj),
    .iexposure_dec_p (iexposure_dec_p),
    .izoom_mode_sw   (izoom_mode_sw),
    .cmd             (bus),
    .obusy           (obusy),
    .oconfig_done    (oconfig_done),
    .oerror          (oerror),
    .oexposure       (oexposure)
  );

  always #5 iclk = ~iclk;

  // I2C master model: logs accepted writes, pulses done four cycles later.
  initial begin
    bus.icmd_done = 1'b0;
    bus.icmd_nack = 1'b0;
    forever begin
      @(negedge iclk);
      bus.icmd_done = 1'b0;
      bus.icmd_nack = 1'b0;
      if (rsp_timer > 0) begin
        rsp_timer--;
        if (rsp_timer == 0) begin
          bus.icmd_done = 1'b1;
          if (nack_left > 0 && rsp_reg == nack_reg) begin
            bus.icmd_nack = 1'b1;
            nack_left--;
          end
        end
      end
      if (bus.ocmd_valid && bus.icmd_ready) begin
        log_reg.push_back(bus.ocmd_reg);
        log_data.push_back(bus.ocmd_data);
        rsp_reg = bus.ocmd_reg;
        rsp_timer = 4;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge iclk);
    #1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (oconfig_done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_log(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (log_reg.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic clear_log();
    log_reg.delete();
    log_data.delete();
  endtask

  task automatic pulse_start();
    istart_cfg = 1'b1;
    tick(1);
    istart_cfg = 1'b0;
  endtask

  task automatic pulse_adj(input logic dec);
    iexposure_dec_p = dec;
    iexposure_adj = 1'b1;
    tick(6);
    iexposure_adj = 1'b0;
    tick(30);
  endtask

  task automatic test_reset();
    irst = 1'b0;
    tick(3);
    n_checks++; if (obusy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", obusy); end
    n_checks++; if (bus.ocmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.ocmd_valid); end
    n_checks++; if (oconfig_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", oconfig_done); end
    n_checks++; if (oerror !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", oerror); end
    n_checks++; if (oexposure !== 16'h0797) begin n_fail++; $display("FAIL reset_exposure: got %h expected 0797", oexposure); end
    n_checks++; if (bus.ocmd_slave !== 8'hBA) begin n_fail++; $display("FAIL reset_slave: got %h expected ba", bus.ocmd_slave); end
  endtask

  task automatic test_initial_sequence();
    bit ok;
    clear_log();
    irst = 1'b1;
    tick(15);
    n_checks++; if (bus.ocmd_valid !== 1'b0) begin n_fail++; $display("FAIL settle_early: valid got %b expected 0", bus.ocmd_valid); end
    tick(1);
    n_checks++; if (bus.ocmd_valid !== 1'b1) begin n_fail++; $display("FAIL settle_end: valid got %b expected 1", bus.ocmd_valid); end
    wait_done(400, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL init_done_timeout: done got %b expected 1", oconfig_done); end
    n_checks++; if (log_reg.size() != 8) begin n_fail++; $display("FAIL init_count: got %0d expected 8", log_reg.size()); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (log_reg[i] !== EXP_REGS[i] || log_data[i] !== EXP_DATA[i]) begin
        n_fail++;
        $display("FAIL init_entry%0d: got %h/%h expected %h/%h", i, log_reg[i], log_data[i], EXP_REGS[i], EXP_DATA[i]);
      end
    end
    n_checks++; if (oexposure !== 16'h0797) begin n_fail++; $display("FAIL init_exposure: got %h expected 0797", oexposure); end
    n_checks++; if (obusy !== 1'b0) begin n_fail++; $display("FAIL init_busy: got %b expected 0", obusy); end
  endtask

  task automatic test_exposure_increment();
    logic [15:0] want;
    for (int k = 0; k < 2; k++) begin
      want = (k == 0) ? 16'h0897 : 16'h0997;
      clear_log();
      pulse_adj(1'b0);
      n_checks++;
      if (log_reg.size() != 1 || log_reg[0] !== 8'h09 || log_data[0] !== want) begin
        n_fail++;
        $display("FAIL exp_inc%0d: got n=%0d %h/%h expected n=1 09/%h", k, log_reg.size(), log_reg[0], log_data[0], want);
      end
    end
    n_checks++; if (oexposure !== 16'h0997) begin n_fail++; $display("FAIL exp_inc_out: got %h expected 0997", oexposure); end
    n_checks++; if (oconfig_done !== 1'b1) begin n_fail++; $display("FAIL exp_inc_done: got %b expected 1", oconfig_done); end
  endtask

  task automatic test_exposure_saturate();
    logic [15:0] want = 16'h0997;
    for (int k = 0; k < 11; k++) begin
      want = (want >= 16'h0100) ? want - 16'h0100 : 16'h0000;
      clear_log();
      pulse_adj(1'b1);
      n_checks++;
      if (log_reg.size() != 1 || log_data[0] !== want) begin
        n_fail++;
        $display("FAIL exp_dec%0d: got n=%0d data=%h expected n=1 data=%h", k, log_reg.size(), log_data[0], want);
      end
    end
    n_checks++; if (oexposure !== 16'h0000) begin n_fail++; $display("FAIL exp_sat_out: got %h expected 0000", oexposure); end
  endtask

  task automatic test_ready_stall();
    bit ok;
    clear_log();
    cmd_ready = 1'b0;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.ocmd_valid === 1'b1) begin ok = 1'b1; break; end
      tick(1);
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_start: valid got %b expected 1", bus.ocmd_valid); end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (bus.ocmd_valid !== 1'b1 || bus.ocmd_reg !== 8'h01 || bus.ocmd_data !== 16'h0036) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got %b %h/%h expected 1 01/0036", i, bus.ocmd_valid, bus.ocmd_reg, bus.ocmd_data);
      end
      tick(1);
    end
    n_checks++; if (log_reg.size() != 0) begin n_fail++; $display("FAIL stall_accept: got %0d writes expected 0", log_reg.size()); end
    cmd_ready = 1'b1;
    wait_log(2, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_resume: got %0d writes expected 2", log_reg.size()); end
    tick(2);
    irst = 1'b0;
    tick(1);
    n_checks++; if (obusy !== 1'b1 || bus.ocmd_valid !== 1'b0) begin n_fail++; $display("FAIL midwait_rst_ctl: got busy=%b valid=%b expected 1 0", obusy, bus.ocmd_valid); end
    n_checks++; if (oconfig_done !== 1'b0 || oerror !== 1'b0) begin n_fail++; $display("FAIL midwait_rst_flags: got done=%b err=%b expected 0 0", oconfig_done, oerror); end
    n_checks++; if (oexposure !== 16'h0797) begin n_fail++; $display("FAIL midwait_rst_exp: got %h expected 0797", oexposure); end
    tick(3);
    irst = 1'b1;
    clear_log();
    wait_done(400, ok);
    n_checks++; if (!ok || log_reg.size() != 8) begin n_fail++; $display("FAIL rerun_after_rst: got %0d writes expected 8", log_reg.size()); end
    n_checks++; if (log_data[1] !== 16'h0797) begin n_fail++; $display("FAIL rerun_exp: got %h expected 0797", log_data[1]); end
  endtask

  task automatic test_nack_error();
    bit ok;
    int n3;
    clear_log();
    nack_reg = 8'h03;
    nack_left = 4;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (oerror === 1'b1) begin ok = 1'b1; break; end
      tick(1);
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL nack_error: oerror got %b expected 1", oerror); end
    n3 = 0;
    foreach (log_reg[i]) if (log_reg[i] == 8'h03) n3++;
    n_checks++; if (n3 != 4 || log_reg.size() != 7) begin n_fail++; $display("FAIL nack_issues: got %0d of entry3, %0d total expected 4, 7", n3, log_reg.size()); end
    tick(5);
    n_checks++; if (oerror !== 1'b1 || bus.ocmd_valid !== 1'b0 || obusy !== 1'b0) begin n_fail++; $display("FAIL error_hold: got err=%b valid=%b busy=%b expected 1 0 0", oerror, bus.ocmd_valid, obusy); end
    clear_log();
    istart_cfg = 1'b1;
    tick(1);
    istart_cfg = 1'b0;
    n_checks++; if (oerror !== 1'b0 || bus.ocmd_valid !== 1'b1 || bus.ocmd_reg !== 8'h01) begin n_fail++; $display("FAIL error_restart: got err=%b valid=%b reg=%h expected 0 1 01", oerror, bus.ocmd_valid, bus.ocmd_reg); end
    wait_done(400, ok);
    tick(20);
    n_checks++; if (!ok || log_reg.size() != 8) begin n_fail++; $display("FAIL restart_run: got %0d writes expected 8", log_reg.size()); end
  endtask

  task automatic test_zoom_during_run();
    bit ok;
    clear_log();
    pulse_start();
    wait_log(3, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL zoom_entry2: got %0d writes expected 3", log_reg.size()); end
    izoom_mode_sw = 1'b1;
    iexposure_dec_p = 1'b0;
    iexposure_adj = 1'b1;
    tick(6);
    iexposure_adj = 1'b0;
    wait_log(16, 400, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL zoom_rerun: got %0d writes expected 16", log_reg.size()); end
    wait_done(100, ok);
    tick(30);
    n_checks++; if (log_reg.size() != 16) begin n_fail++; $display("FAIL zoom_no_extra: got %0d writes expected 16", log_reg.size()); end
    n_checks++;
    if (log_reg[13] !== 8'h22 || log_data[13] !== 16'h0000 || log_reg[14] !== 8'h23 || log_data[14] !== 16'h0000) begin
      n_fail++;
      $display("FAIL zoom_skip: got %h/%h %h/%h expected 22/0000 23/0000", log_reg[13], log_data[13], log_reg[14], log_data[14]);
    end
    n_checks++; if (log_reg[9] !== 8'h09 || log_data[9] !== 16'h0897) begin n_fail++; $display("FAIL zoom_exp: got %h/%h expected 09/0897", log_reg[9], log_data[9]); end
    n_checks++; if (oexposure !== 16'h0897 || oconfig_done !== 1'b1) begin n_fail++; $display("FAIL zoom_final: got exp=%h done=%b expected 0897 1", oexposure, oconfig_done); end
  endtask

  initial begin
    test_reset();
    test_initial_sequence();
    test_exposure_increment();
    test_exposure_saturate();
    test_ready_stall();
    test_nack_error();
    test_zoom_during_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ccd_config_sequencer.md
CCD_CONFIG_SEQUENCER -- requirements
Module: ccd_config_sequencer

Interface
REQ-001 Parameter SLAVE_ADDR, default 8'hBA: sensor I2C write address placed on ocmd_slave.
REQ-002 Parameter EXP_DEFAULT, default 16'h0797: exposure value after reset.
REQ-003 Parameter EXP_STEP, default 16'h0100: exposure increment/decrement per adjust event.
REQ-004 Parameter MAX_RETRY, default 3: retries per table entry after NACK.
REQ-005 Parameter SETTLE_CYCLES, default 16: idle cycles after reset before the first sequence.
REQ-006 Port iclk, input, 1: sole clock; all logic on its rising edge.
REQ-007 Port irst, input, 1: reset; synchronous and active-low.
REQ-008 Port istart_cfg, input, 1: single-cycle pulse requesting a full re-sequence.
REQ-009 Port iexposure_adj, input, 1: asynchronous push-button level; rising edge requests an exposure change.
REQ-010 Port iexposure_dec_p, input, 1: exposure direction; 1 = decrement, 0 = increment; sampled with the adjust edge.
REQ-011 Port izoom_mode_sw, input, 1: asynchronous switch level; 1 = zoom (full-resolution) mode.
REQ-012 Port ocmd_valid / ocmd_slave[7:0] / ocmd_reg[7:0] / ocmd_data[15:0], output: write command to the I2C master.
REQ-013 Port icmd_ready, input, 1: I2C master accepts the command in any cycle where ocmd_valid and icmd_ready are both 1.
REQ-014 Port icmd_done / icmd_nack, input, 1 each: one-cycle completion pulse; icmd_nack qualifies icmd_done.
REQ-015 Port obusy / oconfig_done / oerror, output, 1 each: status flags.
REQ-016 Port oexposure, output, 16: exposure value currently applied.

Function
REQ-017 States: SETTLE, IDLE, ISSUE, WAIT, NEXT, DONE, ERROR.
- SETTLE counts SETTLE_CYCLES, then enters ISSUE at index 0.
- IDLE is unused after the first run.
REQ-018 Configuration table: 8 entries, index 0-7 (reg, data); entry 1 is reg 8'h09 carrying the exposure register value; entries 5 and 6 (regs 8'h22, 8'h23) carry 16'h0000 when zoom = 1 and 16'h0033 otherwise; all other entries are constants from the package.
REQ-019 ISSUE: ocmd_valid = 1 with payload stable until acceptance; move to WAIT in the cycle after acceptance.
REQ-020 WAIT: on icmd_done && !icmd_nack, go to NEXT; on icmd_done && icmd_nack, handle the retry.
- If retry count < MAX_RETRY: increment the count and return to ISSUE with the same entry.
- Otherwise: go to ERROR.
REQ-021 NEXT: clear the retry count; increment the index; after index 7, or after the single entry of an exposure-only update, go to DONE.
REQ-022 Input synchronisation: iexposure_adj and izoom_mode_sw each pass a 2-flop synchroniser; edge detection uses the synchronised signals.
REQ-023 Exposure edge: increment or decrement the exposure register by EXP_STEP.
- Saturate at 16'h0000 and 16'hFFFF; no wraparound.
- Update the register in the cycle after the synchronised edge.
REQ-024 Zoom change: any change of the synchronised zoom level sets pending-full.
REQ-025 Exposure edge sets pending-exp; istart_cfg sets pending-full.
- Pending flags are serviced only from DONE.
- pending-full takes priority and clears both flags.
- pending-exp alone issues entry 1 only.
REQ-026 Events during ISSUE/WAIT/NEXT are latched, never dropped; a full run in progress uses the zoom/exposure values sampled when each entry issues.
REQ-027 ERROR: ocmd_valid = 0, oerror = 1.
- Only istart_cfg leaves ERROR; it clears oerror and restarts at index 0.
- Exposure and zoom events set pending flags only.
REQ-028 Status flags: obusy = 1 in SETTLE, ISSUE, WAIT, NEXT; oconfig_done = 1 only in DONE; oexposure = register value last acknowledged at entry 1.
REQ-029 Fixed output: ocmd_slave always equals SLAVE_ADDR.

Reset
REQ-030 On irst = 0 at a clock edge, apply the following:
- state = SETTLE, counter = 0, index = 0, retry = 0;
- pending flags cleared;
- exposure = EXP_DEFAULT, oexposure = EXP_DEFAULT;
- ocmd_valid, oconfig_done, oerror = 0, obusy = 1;
- synchronisers = 0.
REQ-031 Reset asserted mid-transaction abandons the command immediately; a later icmd_done is ignored until state WAIT is re-entered.

Structure
REQ-032 Shared package ccd_cfg_pkg holds the following:
- state enum;
- table length 8;
- register addresses, including 8'h09, 8'h22 and 8'h23;
- constant table data.
REQ-033 One sub-module, ccd_cfg_rom: combinational index/zoom/exposure -> reg, data lookup.

Verification
REQ-034 Reset release, icmd_ready = 1, done after 4 cycles each -> after 16 cycles, 8 writes; entry 1 = (8'h09, 16'h0797); DONE, oconfig_done = 1.
REQ-035 Two increment edges in DONE -> two single writes to 8'h09 with 16'h0897 then 16'h0997; oexposure = 16'h0997.
REQ-036 Exposure 16'h0050, decrement edge -> write 16'h0000; a further decrement writes 16'h0000 again.
REQ-037 NACK on entry 3 four times -> 4 issues of entry 3, then ERROR with oerror = 1; istart_cfg -> restart at entry 0.
REQ-038 Zoom toggled and exposure edge during entry 2 -> sequence finishes, then one full rerun with entries 5/6 = 16'h0000; no separate exposure-only write.
REQ-039 icmd_ready held 0 for 10 cycles -> ocmd_valid and payload held stable for 10 cycles; reset mid-WAIT -> SETTLE with outputs at reset values.
